cdb_arbiter: RTL



---
 rtl/sys_defs.sv | 46 ++++
 rtl/rr_pick2.sv | 38 +++
 rtl/cdb_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sys_defs.sv
// Shared core definitions: sizes, FU requester indices, CDB packet.
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

package sys_defs;

   localparam int PRF_SIZE = `PRF_SIZE;
   localparam int ROB_SIZE = `ROB_SIZE;
   localparam int NUM_FU   = 6;
   localparam int TAG_W    = $clog2(PRF_SIZE);
   localparam int ROB_W    = $clog2(ROB_SIZE);

   localparam int FU1_ADD  = 0;
   localparam int FU1_MUL  = 1;
   localparam int FU1_MEM  = 2;
   localparam int FU2_ADD  = 3;
   localparam int FU2_MUL  = 4;
   localparam int FU2_MEM  = 5;

   typedef struct packed {
      logic [63:0]      data;
      logic [TAG_W-1:0] tag;
      logic [ROB_W-1:0] rob_idx;
      logic             valid;
   } CDB_PACKET;

   // Circular index reduction for sums of two values in 0..5.
   function automatic logic [2:0] wrap6(input logic [3:0] v);
      logic [3:0] r;
      r = (v >= 4'd6) ? v - 4'd6 : v;
      return r[2:0];
   endfunction

   function automatic logic [2:0] popcount6(input logic [5:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 6; i++)
         n = n + {2'b00, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-winner circular priority picker over six requesters,
// starting the search at ptr.
module rr_pick2
   import sys_defs::*;
(
   input  logic [5:0] valid,
   input  logic [2:0] ptr,
   output logic [5:0] grant1,
   output logic [5:0] grant2,
   output logic [2:0] next_ptr
);

   logic [1:0] hits;
   logic [2:0] idx;

   always_comb begin
      grant1   = '0;
      grant2   = '0;
      next_ptr = ptr;
      hits     = 2'd0;
      idx      = '0;
      for (int k = 0; k < 6; k++) begin
         idx = wrap6({1'b0, ptr} + 4'(k));
         if (valid[idx]) begin
            if (hits == 2'd0) begin
               grant1[idx] = 1'b1;
               next_ptr    = wrap6({1'b0, idx} + 4'd1);
               hits        = 2'd1;
            end else if (hits == 2'd1) begin
               grant2[idx] = 1'b1;
               next_ptr    = wrap6({1'b0, idx} + 4'd1);
               hits        = 2'd2;
            end
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Completion buffer for six FUs sharing two CDBs round-robin;
// also drives the per-unit issue-available flags.
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

module cdb_arbiter
   import sys_defs::*;
#(
   parameter int PRF_SIZE = `PRF_SIZE,
   parameter int ROB_SIZE = `ROB_SIZE,
   parameter int NUM_FU   = 6
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               flush,
   input  logic [NUM_FU-1:0]                  fu_done,
   input  logic [NUM_FU-1:0][63:0]            fu_result,
   input  logic [NUM_FU-1:0][$clog2(PRF_SIZE)-1:0] fu_dest_tag,
   input  logic [NUM_FU-1:0][$clog2(ROB_SIZE)-1:0] fu_rob_idx,
   output logic                               fu1_adder_available,
   output logic                               fu1_mult_available,
   output logic                               fu1_memory_available,
   output logic                               fu2_adder_available,
   output logic                               fu2_mult_available,
   output logic                               fu2_memory_available,
   output logic [63:0]                        rs_cdb1_in,
   output logic [63:0]                        rs_cdb2_in,
   output logic [$clog2(PRF_SIZE)-1:0]        rs_cdb1_tag,
   output logic [$clog2(PRF_SIZE)-1:0]        rs_cdb2_tag,
   output logic [$clog2(ROB_SIZE)-1:0]        rs_cdb1_rob_idx,
   output logic [$clog2(ROB_SIZE)-1:0]        rs_cdb2_rob_idx,
   output logic                               rs_cdb1_valid,
   output logic                               rs_cdb2_valid,
   output logic [2:0]                         pending_count,
   output logic                               overflow_err
);

   localparam int TW = $clog2(PRF_SIZE);
   localparam int RW = $clog2(ROB_SIZE);

   typedef struct packed {
      logic [63:0]   data;
      logic [TW-1:0] tag;
      logic [RW-1:0] rob;
   } slot_t;

   slot_t             slot [NUM_FU];
   logic [5:0]        slot_valid;
   logic [5:0]        valid_nxt;
   logic [5:0]        capture;
   logic [5:0]        grant1;
   logic [5:0]        grant2;
   logic [2:0]        rr_ptr;
   logic [2:0]        next_ptr;
   slot_t             pick1;
   slot_t             pick2;
   slot_t             cdb1;
   slot_t             cdb2;
   logic              cdb1_v;
   logic              cdb2_v;
   logic              use1;
   logic              use2;

   rr_pick2 u_pick (
      .valid    (slot_valid),
      .ptr      (rr_ptr),
      .grant1   (grant1),
      .grant2   (grant2),
      .next_ptr (next_ptr)
   );

   always_comb begin
      pick1 = '0;
      pick2 = '0;
      for (int i = 0; i < 6; i++) begin
         if (grant1[i]) pick1 = slot[i];
         if (grant2[i]) pick2 = slot[i];
      end
   end

   // A slot granted this edge stays busy for that edge's done.
   assign capture   = flush ? 6'b0 : (fu_done & ~slot_valid);
   assign valid_nxt = flush ? 6'b0
                    : ((slot_valid & ~(grant1 | grant2)) | capture);
   assign use1      = !flush && (|grant1);
   assign use2      = !flush && (|grant2);

   always_ff @(posedge clock) begin
      for (int i = 0; i < 6; i++) begin
         if (capture[i]) begin
            slot[i].data <= fu_result[i];
            slot[i].tag  <= fu_dest_tag[i];
            slot[i].rob  <= fu_rob_idx[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         slot_valid    <= '0;
         pending_count <= '0;
         rr_ptr        <= '0;
         overflow_err  <= 1'b0;
         cdb1          <= '0;
         cdb2          <= '0;
         cdb1_v        <= 1'b0;
         cdb2_v        <= 1'b0;
      end else begin
         slot_valid    <= valid_nxt;
         pending_count <= popcount6(valid_nxt);
         if (!flush) rr_ptr <= next_ptr;
         if (!flush && |(fu_done & slot_valid))
            overflow_err <= 1'b1;
         cdb1_v <= use1;
         cdb2_v <= use2;
         if (use1) cdb1 <= pick1;
         if (use2) cdb2 <= pick2;
      end
   end

   assign fu1_adder_available  = ~slot_valid[FU1_ADD];
   assign fu1_mult_available   = ~slot_valid[FU1_MUL];
   assign fu1_memory_available = ~slot_valid[FU1_MEM];
   assign fu2_adder_available  = ~slot_valid[FU2_ADD];
   assign fu2_mult_available   = ~slot_valid[FU2_MUL];
   assign fu2_memory_available = ~slot_valid[FU2_MEM];

   assign rs_cdb1_in      = cdb1.data;
   assign rs_cdb1_tag     = cdb1.tag;
   assign rs_cdb1_rob_idx = cdb1.rob;
   assign rs_cdb1_valid   = cdb1_v;
   assign rs_cdb2_in      = cdb2.data;
   assign rs_cdb2_tag     = cdb2.tag;
   assign rs_cdb2_rob_idx = cdb2.rob;
   assign rs_cdb2_valid   = cdb2_v;

endmodule
